// File: rtl/ibex_rf_wipe_ctrl_if.sv
// rtl/ibex_rf_wipe_ctrl_if.sv - writeback-in / register-file-write-out port bundle
interface ibex_rf_wipe_ctrl_if #(
   parameter int unsigned DataWidth = 32
);
   logic [4:0]           core_waddr;
   logic [DataWidth-1:0] core_wdata;
   logic                 core_we;
   logic [4:0]           rf_waddr;
   logic [DataWidth-1:0] rf_wdata;
   logic                 rf_we;

   // Writeback side: drives the core write port, observes what reaches the RF
   modport master (
      output core_waddr, core_wdata, core_we,
      input  rf_waddr, rf_wdata, rf_we
   );

   // Sequencer side: consumes the core write port, drives the RF write port
   modport slave (
      input  core_waddr, core_wdata, core_we,
      output rf_waddr, rf_wdata, rf_we
   );
endinterface

// File: rtl/ibex_rf_wipe_ctrl.sv
// rtl/ibex_rf_wipe_ctrl.sv - register file wipe sequencer with writeback pass-through
module ibex_rf_wipe_ctrl #(
   parameter bit                   RV32E       = 1'b0,
   parameter int unsigned          DataWidth   = 32,
   parameter logic [DataWidth-1:0] WordZeroVal = '0,
   parameter bit                   TwoPass     = 1'b1,
   parameter logic [DataWidth-1:0] LfsrSeed    = 32'hACE1_2468,
   parameter logic [DataWidth-1:0] LfsrPoly    = 32'h8020_0003
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wipe_req_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   ibex_rf_wipe_ctrl_if.slave wb
);

   localparam int unsigned NumWords  = RV32E ? 16 : 32;
   localparam int unsigned AddrWidth = RV32E ? 4 : 5;
   localparam logic [AddrWidth-1:0] CntOne  = AddrWidth'(1);
   localparam logic [AddrWidth-1:0] CntLast = AddrWidth'(NumWords - 1);

   typedef enum logic [1:0] {
      IDLE,
      NOISE,
      ZERO
   } state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] cnt_q, cnt_d;
   logic [DataWidth-1:0] lfsr_q, lfsr_d, lfsr_next;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic [4:0]           rf_waddr;
   logic [DataWidth-1:0] rf_wdata;
   logic                 rf_we;
   logic                 busy;

   // Galois LFSR step: shift right, fold the taps in when a one falls out
   assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrPoly) : (lfsr_q >> 1);

   // State, counter, noise generator and pulse flops; reset drops any wipe in progress
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= CntOne;
         lfsr_q  <= LfsrSeed;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next state and write-port mux; a busy cycle always owns the RF port, core writes are dropped
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lfsr_d   = lfsr_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      rf_waddr = wb.core_waddr;
      rf_wdata = wb.core_wdata;
      rf_we    = wb.core_we;
      busy     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wipe_req_i) begin
               state_d = TwoPass ? NOISE : ZERO;
               cnt_d   = CntOne;
            end
         end
         NOISE: begin
            busy     = 1'b1;
            rf_we    = 1'b1;
            rf_waddr = 5'(cnt_q);
            rf_wdata = lfsr_q;
            lfsr_d   = lfsr_next;
            err_d    = wb.core_we;
            if (cnt_q == CntLast) begin
               state_d = ZERO;
               cnt_d   = CntOne;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         ZERO: begin
            busy     = 1'b1;
            rf_we    = 1'b1;
            rf_waddr = 5'(cnt_q);
            rf_wdata = WordZeroVal;
            err_d    = wb.core_we;
            if (cnt_q == CntLast) begin
               state_d = IDLE;
               cnt_d   = CntOne;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CntOne;
         end
      endcase
   end

   assign wb.rf_waddr = rf_waddr;
   assign wb.rf_wdata = rf_wdata;
   assign wb.rf_we    = rf_we;
   assign busy_o      = busy;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_ibex_rf_wipe_ctrl.sv
// tb/tb_ibex_rf_wipe_ctrl.sv - scoreboard bench for the register file wipe sequencer
module tb_ibex_rf_wipe_ctrl;

   localparam logic [31:0] Seed = 32'hACE1_2468;
   localparam logic [31:0] Poly = 32'h8020_0003;

   typedef struct {
      int          cyc;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_a = 1'b0, req_b = 1'b0;
   logic busy_a, done_a, err_a, busy_b, done_b, err_b;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   wr_t wq_a[$];
   wr_t wq_b[$];
   int  dq_a[$];
   int  dq_b[$];
   int  eq_a[$];
   logic [31:0] lfsr_m = Seed;
   logic [31:0] rf_m[32];

   ibex_rf_wipe_ctrl_if #(.DataWidth(32)) ifa ();
   ibex_rf_wipe_ctrl_if #(.DataWidth(32)) ifb ();

   ibex_rf_wipe_ctrl dut_a (
      .clk_i(clk), .rst_i(rst), .wipe_req_i(req_a),
      .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .wb(ifa)
   );

   ibex_rf_wipe_ctrl #(.RV32E(1'b1), .TwoPass(1'b0)) dut_b (
      .clk_i(clk), .rst_i(rst), .wipe_req_i(req_b),
      .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .wb(ifb)
   );

   always #5 clk = ~clk;

   // Free-running cycle index shared by stimulus and monitors
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] pk(input int c, input logic [4:0] a, input logic [31:0] d);
      return {11'b0, c[15:0], a, d};
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ Poly) : (s >> 1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push the expected write stream for a wipe whose request is sampled at the end of cycle c;
   // only events before offset cut are expected (used when reset cuts a wipe short)
   task automatic push_wipe(input bit b, input int c, input int cut);
      int k;
      int nw;
      wr_t e;
      k  = 1;
      nw = b ? 16 : 32;
      for (int p = (b ? 1 : 0); p < 2; p++) begin
         for (int a = 1; a < nw; a++) begin
            e.cyc  = c + k;
            e.addr = 5'(a);
            e.data = (p == 0) ? lfsr_m : 32'h0;
            if (p == 0) lfsr_m = lfsr_step(lfsr_m);
            if (k < cut) begin
               if (b) wq_b.push_back(e);
               else   wq_a.push_back(e);
            end
            k++;
         end
      end
      if (k < cut) begin
         if (b) dq_b.push_back(c + k);
         else   dq_a.push_back(c + k);
      end
   endtask

   task automatic core_wr_a(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      ifa.core_waddr = a;
      ifa.core_wdata = d;
      ifa.core_we    = 1'b1;
      e.cyc = cyc; e.addr = a; e.data = d;
      wq_a.push_back(e);
      tick();
      ifa.core_we = 1'b0;
   endtask

   // Monitor for the default-configuration instance
   always @(negedge clk) begin
      wr_t e;
      if (ifa.rf_we) begin
         rf_m[ifa.rf_waddr] = ifa.rf_wdata;
         if (wq_a.size() == 0) unexpected("a_write", pk(cyc, ifa.rf_waddr, ifa.rf_wdata));
         else begin
            e = wq_a.pop_front();
            check("a_write", pk(cyc, ifa.rf_waddr, ifa.rf_wdata), pk(e.cyc, e.addr, e.data));
         end
      end
      if (done_a) begin
         if (dq_a.size() == 0) unexpected("a_done", 64'(cyc));
         else check("a_done_cycle", 64'(cyc), 64'(dq_a.pop_front()));
      end
      if (err_a) begin
         if (eq_a.size() == 0) unexpected("a_err", 64'(cyc));
         else check("a_err_cycle", 64'(cyc), 64'(eq_a.pop_front()));
      end
   end

   // Monitor for the RV32E single-pass instance
   always @(negedge clk) begin
      wr_t e;
      if (ifb.rf_we) begin
         if (wq_b.size() == 0) unexpected("b_write", pk(cyc, ifb.rf_waddr, ifb.rf_wdata));
         else begin
            e = wq_b.pop_front();
            check("b_write", pk(cyc, ifb.rf_waddr, ifb.rf_wdata), pk(e.cyc, e.addr, e.data));
         end
      end
      if (done_b) begin
         if (dq_b.size() == 0) unexpected("b_done", 64'(cyc));
         else check("b_done_cycle", 64'(cyc), 64'(dq_b.pop_front()));
      end
      if (err_b) unexpected("b_err", 64'(cyc));
   end

   initial begin
      int c;
      ifa.core_waddr = '0; ifa.core_wdata = '0; ifa.core_we = 1'b0;
      ifb.core_waddr = '0; ifb.core_wdata = '0; ifb.core_we = 1'b0;
      for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;

      // Reset state: idle, no pulses, core port passes straight through
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy_a", 64'(busy_a), 64'(0));
      check("rst_done_a", 64'(done_a), 64'(0));
      check("rst_err_a", 64'(err_a), 64'(0));
      check("rst_busy_b", 64'(busy_b), 64'(0));
      ifa.core_waddr = 5'd9; ifa.core_wdata = 32'h55AA_33CC; ifa.core_we = 1'b1;
      #1;
      check("rst_passthru", {31'b0, ifa.rf_we, ifa.rf_waddr, ifa.rf_wdata},
            {31'b0, 1'b1, 5'd9, 32'h55AA_33CC});
      ifa.core_we = 1'b0;
      rst = 1'b0;
      tick();

      // Test 1: preload every register, then a full two-pass wipe
      for (int a = 1; a < 32; a++) core_wr_a(5'(a), 32'hFFFF_FFFF);
      req_a = 1'b1;
      push_wipe(1'b0, cyc, 1000);
      tick();
      req_a = 1'b0;
      repeat (70) tick();
      for (int a = 1; a < 32; a++) check($sformatf("rf_x%0d_zero", a), 64'(rf_m[a]), 64'(0));

      // Test 2: RV32E single zero pass
      req_b = 1'b1;
      push_wipe(1'b1, cyc, 1000);
      tick();
      req_b = 1'b0;
      repeat (20) tick();

      // Test 3: core write in the same idle cycle as the request
      core_wr_a_start: begin
         wr_t e;
         ifa.core_waddr = 5'd5; ifa.core_wdata = 32'h0000_1234; ifa.core_we = 1'b1;
         e.cyc = cyc; e.addr = 5'd5; e.data = 32'h0000_1234;
         wq_a.push_back(e);
         req_a = 1'b1;
         push_wipe(1'b0, cyc, 1000);
         tick();
         ifa.core_we = 1'b0;
         req_a = 1'b0;
      end
      repeat (70) tick();

      // Test 4: core write on wipe cycle 10 is dropped and flagged
      c = cyc;
      req_a = 1'b1;
      push_wipe(1'b0, c, 1000);
      eq_a.push_back(c + 11);
      tick();
      req_a = 1'b0;
      repeat (9) tick();
      ifa.core_waddr = 5'd7; ifa.core_wdata = 32'hDEAD_BEEF; ifa.core_we = 1'b1;
      tick();
      ifa.core_we = 1'b0;
      repeat (60) tick();

      // Test 5: reset at wipe cycle 20, then a fresh wipe from the reseeded LFSR
      c = cyc;
      req_a = 1'b1;
      push_wipe(1'b0, c, 20);
      tick();
      req_a = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", 64'(busy_a), 64'(0));
      check("midrst_we", 64'(ifa.rf_we), 64'(0));
      tick();
      tick();
      lfsr_m = Seed;
      rst = 1'b0;
      repeat (3) tick();
      req_a = 1'b1;
      push_wipe(1'b0, cyc, 1000);
      tick();
      req_a = 1'b0;
      repeat (70) tick();

      // Test 6: request held high across two wipes; second starts right after done
      c = cyc;
      req_a = 1'b1;
      push_wipe(1'b0, c, 1000);
      push_wipe(1'b0, c + 63, 1000);
      repeat (64) tick();
      req_a = 1'b0;
      repeat (70) tick();

      check("a_writes_left", 64'(wq_a.size()), 64'(0));
      check("a_done_left", 64'(dq_a.size()), 64'(0));
      check("a_err_left", 64'(eq_a.size()), 64'(0));
      check("b_writes_left", 64'(wq_b.size()), 64'(0));
      check("b_done_left", 64'(dq_b.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
